// File: rtl/spike_pkg.sv
// Shared widths, record layout and FSM states for the spike output collector.
package spike_pkg;

  localparam int SPK_W    = 16;
  localparam int SUM_W    = 24;
  localparam int REC_W    = 41;

  localparam int SUM_LSB  = 0;
  localparam int PEAK_LSB = 24;
  localparam int FLAT_BIT = 40;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  function automatic logic [REC_W-1:0] pack_rec(input logic             flat,
                                                input logic [SPK_W-1:0] peak,
                                                input logic [SUM_W-1:0] sum);
    logic [REC_W-1:0] rec;
    rec = '0;
    rec[FLAT_BIT]                    = flat;
    rec[PEAK_LSB +: SPK_W]           = peak;
    rec[SUM_LSB +: SUM_W]            = sum;
    return rec;
  endfunction

endpackage

// File: rtl/spike_rec_fifo.sv
// Record FIFO with valid/ready read side; a push into a full FIFO survives only
// when the head is popped on the same edge, otherwise drop_o flags it.
module spike_rec_fifo #(
  parameter int DEPTH = 4,
  parameter int REC_W = 41
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [REC_W-1:0] wr_data_i,
  output logic             drop_o,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [REC_W-1:0] rd_data_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [REC_W-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]      wr_ptr_d, rd_ptr_d;
  logic             empty, full, pop, push_ok;

  // The extra MSB on each pointer separates full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = rd_valid_o && rd_ready_i;
  assign push_ok = wr_en_i && (!full || pop);

  assign drop_o     = wr_en_i && full && !pop;
  assign rd_valid_o = !empty;
  assign rd_data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/spike_out_collector.sv
// Windows sampled TopGrid spike outputs into {flat, peak, sum} records and
// queues them for a valid/ready consumer, counting records lost to a full queue.
module spike_out_collector
  import spike_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SPK_W-1:0] grid_out,
  input  logic             sample_en,
  input  logic [WIN_W-1:0] window_len,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [REC_W-1:0] rec_data,
  output logic             overflow,
  output logic [7:0]       drop_cnt
);

  state_e           state_q, state_d;
  logic [WIN_W-1:0] cnt_q, cnt_d;
  logic [WIN_W-1:0] len_q, len_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [SPK_W-1:0] peak_q, peak_d;
  logic [SPK_W-1:0] first_q, first_d;
  logic             flat_q, flat_d;
  logic             overflow_q;
  logic [7:0]       drop_cnt_q;

  logic             push;
  logic [REC_W-1:0] push_rec;
  logic             drop;

  logic [SUM_W:0]   sum_acc;
  logic [SUM_W-1:0] sum_next;
  logic [SPK_W-1:0] peak_next;
  logic             flat_next;
  logic [WIN_W-1:0] cnt_next;
  logic [WIN_W-1:0] len_open;

  // Sum only saturates when WIN_W allows more than 255 full-scale samples.
  assign sum_acc   = {1'b0, sum_q} + (SUM_W+1)'(grid_out);
  assign sum_next  = sum_acc[SUM_W] ? {SUM_W{1'b1}} : sum_acc[SUM_W-1:0];
  assign peak_next = (grid_out > peak_q) ? grid_out : peak_q;
  assign flat_next = flat_q && (grid_out == first_q);
  assign cnt_next  = cnt_q + WIN_W'(1);
  assign len_open  = (window_len == '0) ? WIN_W'(1) : window_len;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    sum_d    = sum_q;
    peak_d   = peak_q;
    first_d  = first_q;
    flat_d   = flat_q;
    push     = 1'b0;
    push_rec = '0;
    case (state_q)
      IDLE: begin
        if (sample_en) begin
          len_d   = len_open;
          cnt_d   = WIN_W'(1);
          sum_d   = SUM_W'(grid_out);
          peak_d  = grid_out;
          first_d = grid_out;
          flat_d  = 1'b1;
          // A one-sample window opens and closes on the same edge.
          if (len_open == WIN_W'(1)) begin
            push     = 1'b1;
            push_rec = pack_rec(1'b1, grid_out, SUM_W'(grid_out));
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (sample_en) begin
          cnt_d  = cnt_next;
          sum_d  = sum_next;
          peak_d = peak_next;
          flat_d = flat_next;
          if (cnt_next == len_q) begin
            push     = 1'b1;
            push_rec = pack_rec(flat_next, peak_next, sum_next);
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      sum_q      <= '0;
      peak_q     <= '0;
      first_q    <= '0;
      flat_q     <= 1'b1;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      peak_q  <= peak_d;
      first_q <= first_d;
      flat_q  <= flat_d;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  spike_rec_fifo #(
    .DEPTH (DEPTH),
    .REC_W (REC_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (push),
    .wr_data_i  (push_rec),
    .drop_o     (drop),
    .rd_valid_o (rec_valid),
    .rd_ready_i (rec_ready),
    .rd_data_o  (rec_data)
  );

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_spike_out_collector.sv
// Directed self-checking bench for spike_out_collector with hand-computed records.
module tb_spike_out_collector;

  logic        clk;
  logic        rst_n;
  logic [15:0] grid_out;
  logic        sample_en;
  logic [7:0]  window_len;
  logic        rec_valid;
  logic        rec_ready;
  logic [40:0] rec_data;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int testsRun;
  int testsFailed;

  spike_out_collector #(
    .DEPTH (4),
    .WIN_W (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .grid_out   (grid_out),
    .sample_en  (sample_en),
    .window_len (window_len),
    .rec_valid  (rec_valid),
    .rec_ready  (rec_ready),
    .rec_data   (rec_data),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [40:0] mkRec(input logic flat, input logic [15:0] peak,
                                        input logic [23:0] sum);
    return {flat, peak, sum};
  endfunction

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sample_en = 1'b0; grid_out = '0; window_len = 8'd4; rec_ready = 1'b0;
    tick(); tick();
    testsRun++;
    if (rec_valid !== 1'b0 || rec_data !== 41'd0 || overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_state: valid=%b data=%h ovf=%b drops=%0d, want 0/0/0/0",
               rec_valid, rec_data, overflow, drop_cnt);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [15:0] vals [4];
    vals = '{16'd10, 16'd20, 16'd30, 16'd40};
    window_len = 8'd4; rec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      testsRun++;
      if (rec_valid !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL basic_early_valid[%0d]: valid=%b want 0", i, rec_valid);
      end
      sample_en = 1'b1; grid_out = vals[i];
      tick();
    end
    sample_en = 1'b0;
    testsRun++;
    if (rec_valid !== 1'b1 || rec_data !== mkRec(1'b0, 16'd40, 24'd100)) begin
      testsFailed++;
      $display("[TB] FAIL basic_record: valid=%b data=%h want 1/%h",
               rec_valid, rec_data, mkRec(1'b0, 16'd40, 24'd100));
    end
    tick();
    testsRun++;
    if (rec_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL basic_single_cycle: valid=%b want 0", rec_valid);
    end
  endtask

  task automatic test_flat();
    window_len = 8'd3; rec_ready = 1'b0;
    sample_en = 1'b1; grid_out = 16'h0032; tick();
    sample_en = 1'b0; grid_out = 16'h0099; tick();
    sample_en = 1'b1; grid_out = 16'h0032; tick();
    testsRun++;
    if (rec_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL flat_gap_counted: valid=%b want 0", rec_valid);
    end
    tick();
    sample_en = 1'b0;
    testsRun++;
    if (rec_valid !== 1'b1 || rec_data !== mkRec(1'b1, 16'h0032, 24'd150)) begin
      testsFailed++;
      $display("[TB] FAIL flat_record: valid=%b data=%h want 1/%h",
               rec_valid, rec_data, mkRec(1'b1, 16'h0032, 24'd150));
    end
    rec_ready = 1'b1; tick(); rec_ready = 1'b0;
  endtask

  task automatic test_overflow();
    window_len = 8'd1; rec_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      sample_en = 1'b1; grid_out = 16'(i);
      tick();
    end
    sample_en = 1'b0;
    testsRun++;
    if (rec_valid !== 1'b1 || overflow !== 1'b1 || drop_cnt !== 8'd2) begin
      testsFailed++;
      $display("[TB] FAIL overflow_flags: valid=%b ovf=%b drops=%0d want 1/1/2",
               rec_valid, overflow, drop_cnt);
    end
    rec_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      testsRun++;
      if (rec_valid !== 1'b1 || rec_data !== mkRec(1'b1, 16'(i), 24'(i))) begin
        testsFailed++;
        $display("[TB] FAIL overflow_order[%0d]: valid=%b data=%h want 1/%h",
                 i, rec_valid, rec_data, mkRec(1'b1, 16'(i), 24'(i)));
      end
      tick();
    end
    testsRun++;
    if (rec_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL overflow_drained: valid=%b want 0", rec_valid);
    end
    rec_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    window_len = 8'd1; rec_ready = 1'b0;
    for (int i = 11; i <= 14; i++) begin
      sample_en = 1'b1; grid_out = 16'(i);
      tick();
    end
    sample_en = 1'b1; grid_out = 16'd15; rec_ready = 1'b1;
    tick();
    sample_en = 1'b0;
    testsRun++;
    if (drop_cnt !== 8'd2) begin
      testsFailed++;
      $display("[TB] FAIL fullpop_no_drop: drops=%0d want 2", drop_cnt);
    end
    for (int i = 12; i <= 15; i++) begin
      testsRun++;
      if (rec_valid !== 1'b1 || rec_data !== mkRec(1'b1, 16'(i), 24'(i))) begin
        testsFailed++;
        $display("[TB] FAIL fullpop_head[%0d]: valid=%b data=%h want 1/%h",
                 i, rec_valid, rec_data, mkRec(1'b1, 16'(i), 24'(i)));
      end
      tick();
    end
    testsRun++;
    if (rec_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL fullpop_occupancy: valid=%b want 0", rec_valid);
    end
    rec_ready = 1'b0;
  endtask

  task automatic test_limits();
    window_len = 8'd0; rec_ready = 1'b0;
    sample_en = 1'b1; grid_out = 16'd7; tick();
    grid_out = 16'd9; tick();
    sample_en = 1'b0;
    testsRun++;
    if (rec_data !== mkRec(1'b1, 16'd7, 24'd7)) begin
      testsFailed++;
      $display("[TB] FAIL len0_first: data=%h want %h", rec_data, mkRec(1'b1, 16'd7, 24'd7));
    end
    rec_ready = 1'b1; tick();
    testsRun++;
    if (rec_valid !== 1'b1 || rec_data !== mkRec(1'b1, 16'd9, 24'd9)) begin
      testsFailed++;
      $display("[TB] FAIL len0_second: valid=%b data=%h want 1/%h",
               rec_valid, rec_data, mkRec(1'b1, 16'd9, 24'd9));
    end
    tick();
    rec_ready = 1'b0;
    window_len = 8'd255; sample_en = 1'b1; grid_out = 16'hFFFF;
    tick();
    window_len = 8'd1;
    for (int i = 2; i <= 254; i++) tick();
    testsRun++;
    if (rec_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL len255_early: valid=%b want 0", rec_valid);
    end
    tick();
    sample_en = 1'b0;
    testsRun++;
    if (rec_valid !== 1'b1 || rec_data !== mkRec(1'b1, 16'hFFFF, 24'hFEFF01)) begin
      testsFailed++;
      $display("[TB] FAIL len255_record: valid=%b data=%h want 1/%h",
               rec_valid, rec_data, mkRec(1'b1, 16'hFFFF, 24'hFEFF01));
    end
    testsRun++;
    if (overflow !== 1'b1 || drop_cnt !== 8'd2) begin
      testsFailed++;
      $display("[TB] FAIL sticky_overflow: ovf=%b drops=%0d want 1/2", overflow, drop_cnt);
    end
    rec_ready = 1'b1; tick(); rec_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    window_len = 8'd4; rec_ready = 1'b0;
    sample_en = 1'b1; grid_out = 16'd3; tick(); tick();
    sample_en = 1'b0;
    rst_n = 1'b0; tick();
    testsRun++;
    if (rec_valid !== 1'b0 || rec_data !== 41'd0 || overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_outputs: valid=%b data=%h ovf=%b drops=%0d want 0/0/0/0",
               rec_valid, rec_data, overflow, drop_cnt);
    end
    rst_n = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin
      sample_en = 1'b1; grid_out = 16'd5;
      tick();
    end
    sample_en = 1'b0;
    testsRun++;
    if (rec_valid !== 1'b1 || rec_data !== mkRec(1'b1, 16'd5, 24'd20)) begin
      testsFailed++;
      $display("[TB] FAIL midreset_fresh: valid=%b data=%h want 1/%h",
               rec_valid, rec_data, mkRec(1'b1, 16'd5, 24'd20));
    end
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    test_reset();
    test_basic();
    test_flat();
    test_overflow();
    test_full_pop();
    test_limits();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/spike_out_collector.md
SPIKE_OUT_COLLECTOR -- requirements
Module: spike_out_collector

Interface
REQ-001 Parameter DEPTH, default 4: result FIFO entries; power of two, 2..16.
REQ-002 Parameter WIN_W, default 8: width of window_len.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 grid_out  input  16  TopGrid spike_out_final, sampled when sample_en=1.
REQ-006 sample_en  input  1  qualifies grid_out for the current cycle.
REQ-007 window_len  input  WIN_W  samples per window; 0 is treated as 1.
REQ-008 rec_valid  output  1  FIFO head record available.
REQ-009 rec_ready  input  1  consumer accepts head when rec_valid=1.
REQ-010 rec_data  output  41  {flat[40], peak[39:24], sum[23:0]} of FIFO head.
REQ-011 overflow  output  1  sticky; a record was dropped.
REQ-012 drop_cnt  output  8  dropped-record count, saturating at 255.

Function
REQ-013 FSM states are IDLE and ACCUM.
- IDLE: no window open.
- IDLE -> ACCUM on the first sample_en=1 cycle.
- ACCUM -> IDLE when the window closes.
REQ-014 At window open, window_len is latched (0 -> 1); changes to window_len inside a window have no effect until the next window.
REQ-015 Each sample does the following:
- sum += zero-extended grid_out (24-bit).
- peak = max(peak, grid_out).
- flat cleared if grid_out differs from the window's first sample.
REQ-016 The opening sample counts as sample 1; cycles with sample_en=0 neither count nor alter the accumulators.
REQ-017 The window closes on the cycle its latched-count-th sample is taken.
- The record includes that sample.
- The record is pushed to the FIFO on that same edge.
- rec_valid for an empty FIFO rises the following cycle (1-cycle latency from last sample).
REQ-018 Back-to-back windows: if sample_en=1 in the cycle after a close, that sample opens a new window with no gap.
REQ-019 Push/pop rules:
- A pop occurs when rec_valid and rec_ready are both 1.
- A push to a full FIFO is accepted only if a pop occurs in the same cycle.
- Otherwise the record is dropped, overflow is set and drop_cnt is incremented.
REQ-020 Simultaneous push and pop on an empty FIFO: the pop is not possible because rec_valid=0; the push is accepted.
REQ-021 rec_data is driven directly from the FIFO head register and is stable while rec_valid=1 and rec_ready=0.
REQ-022 FIFO pointers wrap modulo DEPTH; full/empty are distinguished by an extra pointer bit.
REQ-023 Sum cannot overflow: 255 x 0xFFFF < 2^24. For WIN_W > 8, sum saturates at 0xFFFFFF.
REQ-024 overflow and drop_cnt are cleared only by reset.

Reset
REQ-025 When rst_n is asserted:
- State goes to IDLE.
- FIFO is emptied.
- sum, peak and counters are 0; flat is 1.
- rec_valid=0, rec_data=0, overflow=0, drop_cnt=0.
REQ-026 Reset mid-window discards the partial window; no record is emitted for it.
REQ-027 The first valid sample after deassertion opens a fresh window.

Structure
REQ-028 A shared package spike_pkg holds the following:
- SPK_W=16, SUM_W=24, REC_W=41.
- The record field offsets.
- The FSM state enum.
REQ-029 The FIFO is one sub-module, spike_rec_fifo (parameterised DEPTH, REC_W, valid/ready on the read side); windowing logic stays in the top.

Verification
REQ-030 Basic window: window_len=4, grid_out 10,20,30,40 on consecutive cycles, rec_ready=1 -> one record with sum=100, peak=40, flat=0; rec_valid high exactly the cycle after sample 4.
REQ-031 Flat window: window_len=3, grid_out=0x0032 x3 with a sample_en=0 gap after sample 1 -> sum=150, peak=0x0032, flat=1; the gap cycle is not counted.
REQ-032 Overflow: rec_ready=0, window_len=1, six samples -> FIFO holds 4 records, overflow=1, drop_cnt=2. Then pop with rec_ready=1 -> records emerge in order and pointers wrap correctly.
REQ-033 Full + simultaneous pop: FIFO full, rec_ready=1 on the cycle a window closes -> push accepted, no drop, occupancy stays 4.
REQ-034 Limits: window_len=0 gives 1-sample windows. window_len=255 with grid_out=0xFFFF -> sum=0xFEFF01, peak=0xFFFF, flat=1.
REQ-035 Reset mid-window: assert rst_n low after 2 of 4 samples -> no record, all outputs 0. Then 4 fresh samples of 5 -> sum=20.
